clock_divider_bank: RTL and testbench
=====================================

// Module: clock_divider_bank
// PURPOSE
//  Parametrised multi-channel clock divider for the MIPS system: CHANNELS independent
//  dividers with runtime period/duty, per-channel enable, common phase restart.
//  Each channel emits a registered divided clock (clk_out) and a one-cycle tick
//  (clock-enable) per period. Feeds slow CPU stepping, peripheral strobes and display refresh.
//  All logic runs on clk_in; outputs are never used as async clocks inside this block.
// PARAMETERS
//  CHANNELS      2    number of divider channels (1..8)
//  WIDTH         16   width of period/high-count registers and counters
//  DEFAULT_PER   1    reset value of every channel's period register P (period = P+1 cycles)
//  DEFAULT_HIGH  1    reset value of every channel's high-count register H
// PORTS
//  clk_in     in   1                      system clock, all logic on posedge
//  reset      in   1                      synchronous, active-high reset
//  enable     in   CHANNELS               per-channel run enable
//  restart    in   1                      pulse: phase-align all channels to count 0
//  wr_en      in   1                      config write strobe
//  wr_chan    in   $clog2(CHANNELS)|1     channel index for write
//  wr_per     in   WIDTH                  new period value P
//  wr_high    in   WIDTH                  new high count H
//  clk_out    out  CHANNELS               divided clock, registered
//  tick       out  CHANNELS               one-cycle pulse at start of each period, registered
// BEHAVIOUR
//  - Per channel: active regs P_a,H_a; shadow regs P_s,H_s; counter cnt (WIDTH bits).
//  - reset (sync, top priority): cnt=0, P_a=P_s=DEFAULT_PER, H_a=H_s=DEFAULT_HIGH,
//    clk_out=0, tick=0 on the next edge; holds while reset=1.
//  - Write: wr_en && wr_chan<CHANNELS -> P_s,H_s of that channel updated next edge.
//    wr_chan>=CHANNELS ignored. Writes never touch cnt or P_a/H_a directly.
//  - Running (enable=1): cnt_n = (cnt==P_a) ? 0 : cnt+1. On wrap (cnt==P_a) P_a<=P_s,
//    H_a<=H_s; a write to the same channel in the wrap cycle bypasses: new value used.
//  - Outputs (registered, computed from next state): clk_out <= (cnt_n < H_n);
//    tick <= (cnt_n==0). So after enable, first cycle shows cnt=0, tick=1.
//  - Duty: H=0 -> clk_out stuck 0; H>P -> stuck 1; otherwise high H cycles, low P+1-H.
//  - P=0: period 1, tick=1 every cycle, clk_out = (H>0) constant.
//  - Comparisons unsigned, WIDTH bits; cnt never exceeds P_a (wrap covers P_a=2^WIDTH-1).
//  - enable=0: cnt<=0, P_a<=P_s, H_a<=H_s (immediate adopt), clk_out<=0, tick<=0.
//    Re-enable restarts phase at count 0 with tick on the first enabled cycle.
//  - restart=1: every enabled channel behaves as if cnt_n=0 with shadow adopted
//    (tick=1, clk_out=(H_s>0)); disabled channels unaffected. reset overrides restart.
//  - Priority per edge: reset > enable=0 > restart > normal count.
//  - Channels fully independent apart from shared write port and restart.
// STRUCTURE
//  - Package clk_div_pkg: DEFAULT_PER/DEFAULT_HIGH constants, counter typedef of WIDTH,
//    channel-config struct {per, high}.
//  - Sub-module clock_divider_channel: one counter + shadow/active regs + output regs;
//    top instantiates CHANNELS copies in a generate loop and decodes wr_chan.
// TESTING
//  1. reset, defaults (P=1,H=1), enable[0]=1 -> clk_out[0] 1,0,1,0...; tick[0] every 2 cycles.
//  2. write ch0 P=3,H=2, enable -> clk_out 1,1,0,0 repeating; tick on first of each 4 cycles.
//  3. ch0 running P=3; write P=5 mid-period -> current period completes as 4 cycles, next is 6.
//  4. H=0 -> clk_out stays 0, tick every period; H=7,P=3 -> clk_out stays 1.
//  5. ch0 P=3, ch1 P=4 both running, pulse restart -> both tick same cycle, both clk_out=1.
//  6. reset mid-period and wr_chan=CHANNELS write -> outputs 0 next edge, defaults restored,
//     no channel config changed by out-of-range write.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and types for the clock divider bank.
// Reset defaults give every channel a divide-by-two, 50% duty clock.
package clk_div_pkg;

   localparam int CNT_W        = 16;
   localparam int DEFAULT_PER  = 1;
   localparam int DEFAULT_HIGH = 1;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef struct packed {
      cnt_t per;
      cnt_t high;
   } chan_cfg_t;

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: shadow/active period and high-count registers, phase counter,
// and registered clk_out/tick computed from the next counter state.
module clock_divider_channel
   import clk_div_pkg::*;
#(
   parameter int WIDTH    = CNT_W,
   parameter int RST_PER  = 1,
   parameter int RST_HIGH = 1
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             enable,
   input  logic             restart,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_per,
   input  logic [WIDTH-1:0] wr_high,
   output logic             clk_out,
   output logic             tick
);

   typedef struct packed {
      logic [WIDTH-1:0] per;
      logic [WIDTH-1:0] high;
   } cfg_t;

   cfg_t             act, act_n;
   cfg_t             shd, shd_n;
   logic [WIDTH-1:0] cnt, cnt_n;
   logic             running;
   logic             clk_n, tick_n;

   // The first enabled cycle after a disable (or reset) starts a fresh period,
   // so the tick appears on that very cycle rather than one period later.
   always_comb begin
      shd_n = shd;
      if (wr_en) begin
         shd_n.per  = wr_per;
         shd_n.high = wr_high;
      end
      act_n = act;
      cnt_n = cnt + WIDTH'(1);
      if (!enable) begin
         cnt_n = '0;
         act_n = shd_n;
      end else if (!running || restart || (cnt == act.per)) begin
         cnt_n = '0;
         act_n = shd_n;
      end
      clk_n  = enable && (cnt_n < act_n.high);
      tick_n = enable && (cnt_n == '0);
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         cnt      <= '0;
         act.per  <= WIDTH'(RST_PER);
         act.high <= WIDTH'(RST_HIGH);
         shd.per  <= WIDTH'(RST_PER);
         shd.high <= WIDTH'(RST_HIGH);
         running  <= 1'b0;
         clk_out  <= 1'b0;
         tick     <= 1'b0;
      end else begin
         cnt      <= cnt_n;
         act      <= act_n;
         shd      <= shd_n;
         running  <= enable;
         clk_out  <= clk_n;
         tick     <= tick_n;
      end
   end

endmodule

// File: rtl/clock_divider_bank.sv
// Multi-channel clock divider: CHANNELS independent dividers sharing one config
// write port and a common phase restart.
module clock_divider_bank #(
   parameter int CHANNELS     = 2,
   parameter int WIDTH        = clk_div_pkg::CNT_W,
   parameter int DEFAULT_PER  = clk_div_pkg::DEFAULT_PER,
   parameter int DEFAULT_HIGH = clk_div_pkg::DEFAULT_HIGH
) (
   input  logic                                clk_in,
   input  logic                                reset,
   input  logic [CHANNELS-1:0]                 enable,
   input  logic                                restart,
   input  logic                                wr_en,
   input  logic [($clog2(CHANNELS) | 1)-1:0]   wr_chan,
   input  logic [WIDTH-1:0]                    wr_per,
   input  logic [WIDTH-1:0]                    wr_high,
   output logic [CHANNELS-1:0]                 clk_out,
   output logic [CHANNELS-1:0]                 tick
);

   localparam int CH_W = $clog2(CHANNELS) | 1;

   // Out-of-range channel indices match no instance and are silently dropped.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      clock_divider_channel #(
         .WIDTH    (WIDTH),
         .RST_PER  (DEFAULT_PER),
         .RST_HIGH (DEFAULT_HIGH)
      ) u_ch (
         .clk_in  (clk_in),
         .reset   (reset),
         .enable  (enable[i]),
         .restart (restart),
         .wr_en   (wr_en && (wr_chan == CH_W'(i))),
         .wr_per  (wr_per),
         .wr_high (wr_high),
         .clk_out (clk_out[i]),
         .tick    (tick[i])
      );
   end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank: vector table, directed corner
// sequences and randomized traffic against a period-based reference model.
module tb_clock_divider_bank;

   localparam int CH   = 3;
   localparam int W    = 8;
   localparam int CH_W = $clog2(CH) | 1;

   logic            clk_in = 1'b0;
   logic            reset;
   logic [CH-1:0]   enable;
   logic            restart;
   logic            wr_en;
   logic [CH_W-1:0] wr_chan;
   logic [W-1:0]    wr_per;
   logic [W-1:0]    wr_high;
   logic [CH-1:0]   clk_out;
   logic [CH-1:0]   tick;

   int n_cmp = 0;
   int n_bad = 0;

   clock_divider_bank #(
      .CHANNELS (CH),
      .WIDTH    (W)
   ) dut (
      .clk_in  (clk_in),
      .reset   (reset),
      .enable  (enable),
      .restart (restart),
      .wr_en   (wr_en),
      .wr_chan (wr_chan),
      .wr_per  (wr_per),
      .wr_high (wr_high),
      .clk_out (clk_out),
      .tick    (tick)
   );

   always #5 clk_in = ~clk_in;

   // Reference model: position within the current period plus adopted/pending configs.
   int m_pos [CH];
   int m_per [CH];
   int m_high[CH];
   int m_sper[CH];
   int m_shigh[CH];
   bit m_live[CH];
   bit m_clk [CH];
   bit m_tick[CH];

   function void model_edge();
      for (int c = 0; c < CH; c++) begin
         if (reset) begin
            m_pos[c] = 0; m_live[c] = 0;
            m_per[c] = 1; m_high[c] = 1; m_sper[c] = 1; m_shigh[c] = 1;
            m_clk[c] = 0; m_tick[c] = 0;
            continue;
         end
         if (wr_en && int'(wr_chan) == c) begin
            m_sper[c]  = int'(wr_per);
            m_shigh[c] = int'(wr_high);
         end
         if (!enable[c]) begin
            m_pos[c] = 0; m_live[c] = 0;
            m_per[c] = m_sper[c]; m_high[c] = m_shigh[c];
            m_clk[c] = 0; m_tick[c] = 0;
         end else begin
            if (!m_live[c] || restart || (m_pos[c] + 1 == m_per[c] + 1)) begin
               m_per[c]  = m_sper[c];
               m_high[c] = m_shigh[c];
               m_pos[c]  = 0;
            end else begin
               m_pos[c] = m_pos[c] + 1;
            end
            m_live[c] = 1;
            m_tick[c] = (m_pos[c] == 0);
            m_clk[c]  = (m_pos[c] < m_high[c]);
         end
      end
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_model(input string nm);
      for (int c = 0; c < CH; c++) begin
         chk($sformatf("%s clk_out[%0d]", nm, c), 32'(clk_out[c]), 32'(m_clk[c]));
         chk($sformatf("%s tick[%0d]", nm, c), 32'(tick[c]), 32'(m_tick[c]));
      end
   endtask

   task automatic step(input bit r, input logic [CH-1:0] e, input bit s, input bit w,
                       input int ch, input int p, input int h);
      reset   = r;
      enable  = e;
      restart = s;
      wr_en   = w;
      wr_chan = CH_W'(ch);
      wr_per  = W'(p);
      wr_high = W'(h);
      @(posedge clk_in);
      model_edge();
      #1;
   endtask

   typedef struct {
      bit            rst;
      logic [CH-1:0] en;
      bit            we;
      int            ch;
      int            per;
      int            high;
      logic [CH-1:0] exp_clk;
      logic [CH-1:0] exp_tick;
   } vec_t;

   vec_t tbl[15];

   function automatic vec_t mk(bit r, logic [CH-1:0] e, bit w, int ch, int p, int h,
                               logic [CH-1:0] ec, logic [CH-1:0] et);
      vec_t v;
      v.rst = r; v.en = e; v.we = w; v.ch = ch; v.per = p; v.high = h;
      v.exp_clk = ec; v.exp_tick = et;
      return v;
   endfunction

   logic [10:0] exp_t3;
   logic [CH-1:0] on3;

   initial begin
      reset = 1'b1; enable = '0; restart = 1'b0; wr_en = 1'b0;
      wr_chan = '0; wr_per = '0; wr_high = '0;
      on3 = '1;

      // Defaults divide by two; then P=3,H=2 gives 1,1,0,0.
      tbl[0]  = mk(1, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000);
      tbl[1]  = mk(1, 3'b001, 0, 0, 0, 0, 3'b000, 3'b000);
      tbl[2]  = mk(0, 3'b001, 0, 0, 0, 0, 3'b001, 3'b001);
      tbl[3]  = mk(0, 3'b001, 0, 0, 0, 0, 3'b000, 3'b000);
      tbl[4]  = mk(0, 3'b001, 0, 0, 0, 0, 3'b001, 3'b001);
      tbl[5]  = mk(0, 3'b001, 0, 0, 0, 0, 3'b000, 3'b000);
      tbl[6]  = mk(0, 3'b000, 1, 0, 3, 2, 3'b000, 3'b000);
      tbl[7]  = mk(0, 3'b001, 0, 0, 0, 0, 3'b001, 3'b001);
      tbl[8]  = mk(0, 3'b001, 0, 0, 0, 0, 3'b001, 3'b000);
      tbl[9]  = mk(0, 3'b001, 0, 0, 0, 0, 3'b000, 3'b000);
      tbl[10] = mk(0, 3'b001, 0, 0, 0, 0, 3'b000, 3'b000);
      tbl[11] = mk(0, 3'b001, 0, 0, 0, 0, 3'b001, 3'b001);
      tbl[12] = mk(0, 3'b001, 0, 0, 0, 0, 3'b001, 3'b000);
      tbl[13] = mk(0, 3'b001, 0, 0, 0, 0, 3'b000, 3'b000);
      tbl[14] = mk(0, 3'b001, 0, 0, 0, 0, 3'b000, 3'b000);

      for (int i = 0; i < 15; i++) begin
         step(tbl[i].rst, tbl[i].en, 0, tbl[i].we, tbl[i].ch, tbl[i].per, tbl[i].high);
         chk($sformatf("vec%0d clk_out", i), 32'(clk_out), 32'(tbl[i].exp_clk));
         chk($sformatf("vec%0d tick", i), 32'(tick), 32'(tbl[i].exp_tick));
      end

      // Period change mid-period: current 4-cycle period finishes, next is 6.
      exp_t3 = 11'b10000010001;
      step(0, 3'b000, 0, 0, 0, 0, 0);
      for (int i = 0; i < 11; i++) begin
         step(0, 3'b001, 0, (i == 2), 0, 5, 2);
         chk($sformatf("midwrite i%0d tick0", i), 32'(tick[0]), 32'(exp_t3[i]));
         check_model($sformatf("midwrite i%0d", i));
      end

      // Duty extremes on ch0, P=0 on ch1 including same-cycle write bypass.
      step(0, 3'b000, 0, 1, 0, 3, 0);
      for (int i = 0; i < 8; i++) begin
         step(0, 3'b001, 0, 0, 0, 0, 0);
         chk($sformatf("h0 i%0d clk0", i), 32'(clk_out[0]), 32'd0);
         chk($sformatf("h0 i%0d tick0", i), 32'(tick[0]), 32'(i % 4 == 0));
      end
      step(0, 3'b000, 0, 1, 0, 3, 7);
      for (int i = 0; i < 8; i++) begin
         step(0, 3'b001, 0, 0, 0, 0, 0);
         chk($sformatf("h7 i%0d clk0", i), 32'(clk_out[0]), 32'd1);
         chk($sformatf("h7 i%0d tick0", i), 32'(tick[0]), 32'(i % 4 == 0));
      end
      step(0, 3'b000, 0, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 3'b010, 0, 0, 0, 0, 0);
         chk($sformatf("p0h0 i%0d clk1", i), 32'(clk_out[1]), 32'd0);
         chk($sformatf("p0h0 i%0d tick1", i), 32'(tick[1]), 32'd1);
      end
      for (int i = 0; i < 3; i++) begin
         step(0, 3'b010, 0, (i == 0), 1, 0, 1);
         chk($sformatf("p0h1 i%0d clk1", i), 32'(clk_out[1]), 32'd1);
         chk($sformatf("p0h1 i%0d tick1", i), 32'(tick[1]), 32'd1);
      end

      // Common restart aligns two channels running out of phase.
      step(0, 3'b000, 0, 1, 0, 3, 2);
      step(0, 3'b000, 0, 1, 1, 4, 2);
      step(0, 3'b001, 0, 0, 0, 0, 0);
      step(0, 3'b001, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 3'b011, 0, 0, 0, 0, 0);
         check_model($sformatf("pre-restart i%0d", i));
      end
      step(0, 3'b011, 1, 0, 0, 0, 0);
      chk("restart tick", 32'(tick), 32'b011);
      chk("restart clk_out", 32'(clk_out), 32'b011);
      check_model("restart");

      // Out-of-range writes change nothing; reset restores defaults.
      for (int i = 0; i < 3; i++) step(0, on3, 0, 0, 0, 0, 0);
      step(0, on3, 0, 1, 3, 0, 0);
      check_model("oor3");
      step(0, on3, 0, 1, 4, 0, 0);
      check_model("oor4");
      step(0, on3, 0, 1, 7, 6, 6);
      check_model("oor7");
      step(0, 3'b000, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         step(0, on3, 0, 0, 0, 0, 0);
         check_model($sformatf("post-oor i%0d", i));
      end
      step(0, on3, 0, 0, 0, 0, 0);
      step(1, on3, 1, 1, 0, 9, 9);
      chk("reset clk_out", 32'(clk_out), 32'd0);
      chk("reset tick", 32'(tick), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(0, on3, 0, 0, 0, 0, 0);
         chk($sformatf("defaults i%0d clk_out", i), 32'(clk_out), (i % 2 == 0) ? 32'b111 : 32'b000);
         chk($sformatf("defaults i%0d tick", i), 32'(tick), (i % 2 == 0) ? 32'b111 : 32'b000);
      end

      // Full-scale period wraps cleanly after 2^W cycles.
      step(0, 3'b000, 0, 1, 2, 255, 128);
      for (int i = 0; i < 258; i++) begin
         step(0, 3'b100, 0, 0, 0, 0, 0);
         check_model($sformatf("maxper i%0d", i));
         if (i == 0 || i == 255 || i == 256)
            chk($sformatf("maxper i%0d tick2", i), 32'(tick[2]), 32'(i != 255));
      end

      // Randomized traffic against the model.
      begin
         logic [CH-1:0] en_r;
         en_r = '0;
         for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < CH; c++)
               if ($urandom_range(19) == 0) en_r[c] = ~en_r[c];
            step($urandom_range(149) == 0, en_r, $urandom_range(39) == 0,
                 $urandom_range(5) == 0, int'($urandom_range(7)),
                 ($urandom_range(9) == 0) ? 255 : int'($urandom_range(5)),
                 int'($urandom_range(7)));
            check_model($sformatf("rand i%0d", i));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
